branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Execute-stage consumer of the branch comparator outputs (BrEq, BrLT).
- Decodes the branch condition from funct3 and drives the comparator's signed/unsigned select.
- Checks the resolved outcome against the fetch-stage prediction and, on a mismatch, issues a registered PC redirect to fetch plus a one-cycle pipeline flush.
- Holds the redirect with a valid/ready handshake while fetch is busy.

Parameters:
- XLEN, 32, datapath width of PC and target.
- RESET_PC, 32'h0000_2000, value of redirect_pc after reset.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- ex_valid  input  1  execute stage holds a valid instruction this cycle
- ex_is_branch  input  1  instruction is a conditional branch (B-type)
- ex_is_jal  input  1  instruction is JAL
- ex_is_jalr  input  1  instruction is JALR
- ex_funct3  input  3  funct3 field of the instruction
- BrEq  input  1  comparator equal result
- BrLT  input  1  comparator less-than result
- BrUn  output  1  signed/unsigned select driven to the comparator
- ex_pc  input  XLEN  PC of the execute instruction
- ex_target  input  XLEN  computed branch/jump target
- ex_pred_taken  input  1  fetch predicted this instruction taken
- redirect_ready  input  1  fetch accepts the redirect
- redirect_valid  output  1  redirect request pending
- redirect_pc  output  XLEN  corrected fetch PC
- flush  output  1  one-cycle pulse; squash IF/ID instructions
- ex_stall  output  1  hold the execute stage while a redirect is pending

Behaviour:
- Reset (asynchronous; takes effect immediately, even mid-handshake):
  - state=IDLE.
  - redirect_valid=0, flush=0, ex_stall=0, redirect_pc=RESET_PC.
- BrUn is combinational: BrUn = ex_funct3[1] (BLTU/BGEU select unsigned compare). Drive it regardless of ex_valid.
- Taken decode (combinational, conditional branches only):
  - 000 BEQ: BrEq
  - 001 BNE: !BrEq
  - 100 BLT: BrLT
  - 101 BGE: !BrLT
  - 110 BLTU: BrLT
  - 111 BGEU: !BrLT
  - 010/011: not taken, no redirect.
- JAL/JALR: always taken. For JALR, the redirect target is ex_target with bit 0 cleared.
- Correct PC: taken ? target : ex_pc+4. The +4 wraps modulo 2^XLEN.
- Mispredict condition:
  - resolve = ex_valid & (ex_is_branch | ex_is_jal | ex_is_jalr).
  - mispredict = resolve & (taken != ex_pred_taken).
  - JALR additionally always mispredicts, because fetch cannot know its target.
  - A predicted-taken branch trusts the fetch target; the unit does not compare targets.
- State machine:
  - IDLE: when resolve & mispredict, on the next edge load redirect_pc, set redirect_valid=1, pulse flush=1 for exactly that one cycle, and go to REDIRECT. Otherwise stay in IDLE with redirect_valid=0.
  - REDIRECT:
    - redirect_valid=1 and ex_stall=1.
    - redirect_pc is stable until accepted.
    - ex_valid and all other inputs are ignored: they are wrong-path instructions.
    - When redirect_valid & redirect_ready, go to IDLE on the next edge and drop redirect_valid.
    - The cycle of acceptance is not a resolve cycle.
- Latency: resolve at cycle N gives redirect_valid/flush at N+1. The minimum handshake is one cycle if redirect_ready=1 at N+1.
- ex_stall is combinational from state: high in REDIRECT only.
- Back-to-back mispredicts: the first cycle after returning to IDLE may resolve a new mispredict, which starts a new redirect.
- Multiple of ex_is_branch/ex_is_jal/ex_is_jalr asserted at once: priority JALR > JAL > branch.

Optional Feature:
- Macro: BRANCH_RESOLVE_STATS_EN.
- When defined:
  - Add outputs stat_branches[31:0] (counts resolve cycles in IDLE) and stat_mispredicts[31:0] (counts transitions IDLE->REDIRECT).
  - Both counters reset to 0 asynchronously, saturate at 32'hFFFF_FFFF, and are read-only.
- When undefined: the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- BEQ, funct3=000, BrEq=1, pred_taken=0, pc=0x100, target=0x140 -> N+1: redirect_valid=1, redirect_pc=0x140, flush=1 for one cycle; BrUn=0.
- BGEU, funct3=111, BrLT=1, pred_taken=0 -> no redirect, flush=0, BrUn=1.
- BLT, funct3=100, BrLT=0, pred_taken=1, pc=0x200 -> redirect_pc=0x204. Hold redirect_ready=0 for 3 cycles: redirect_valid and ex_stall stay 1, redirect_pc is stable, a new ex_valid branch is ignored; at ready=1 the unit returns to IDLE.
- JALR, target=0x301, pred_taken=1 -> redirect_pc=0x300 (bit 0 cleared).
- Branch not taken with pc=0xFFFF_FFFC, pred_taken=1 -> redirect_pc=0x0000_0000 (wrap).
- Assert reset while in REDIRECT -> redirect_valid=0 and ex_stall=0 immediately (no clock edge), redirect_pc=RESET_PC. With BRANCH_RESOLVE_STATS_EN defined, both counters read 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: decodes the branch condition, detects mispredicts and
// holds a registered fetch redirect under valid/ready. Optional counters: BRANCH_RESOLVE_STATS_EN.
module branch_resolve_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_2000)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic            BrEq,
    input  logic            BrLT,
    output logic            BrUn,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic            redirect_ready,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            ex_stall,
    output logic            dbgState
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } stateT;

    stateT state;
    stateT stateNext;

    logic            condValid;
    logic            branchTaken;
    logic            taken;
    logic            forceMispredict;
    logic            canRedirect;
    logic [XLEN-1:0] takenTarget;
    logic [XLEN-1:0] pcPlus4;
    logic [XLEN-1:0] correctPc;
    logic            resolve;
    logic            mispredict;
    logic            loadRedirect;

    // funct3[1] separates the unsigned compares (BLTU/BGEU) from the signed ones.
    assign BrUn = ex_funct3[1];

    always_comb begin
        condValid   = 1'b0;
        branchTaken = 1'b0;
        case (ex_funct3)
            3'b000: begin condValid = 1'b1; branchTaken = BrEq;  end
            3'b001: begin condValid = 1'b1; branchTaken = !BrEq; end
            3'b100: begin condValid = 1'b1; branchTaken = BrLT;  end
            3'b101: begin condValid = 1'b1; branchTaken = !BrLT; end
            3'b110: begin condValid = 1'b1; branchTaken = BrLT;  end
            3'b111: begin condValid = 1'b1; branchTaken = !BrLT; end
            default: begin condValid = 1'b0; branchTaken = 1'b0; end
        endcase
    end

    // JALR outranks JAL outranks a conditional branch; JALR always redirects since
    // fetch never knows its register-based target.
    always_comb begin
        taken           = 1'b0;
        forceMispredict = 1'b0;
        canRedirect     = 1'b0;
        takenTarget     = ex_target;
        if (ex_is_jalr) begin
            taken           = 1'b1;
            forceMispredict = 1'b1;
            canRedirect     = 1'b1;
            takenTarget     = {ex_target[XLEN-1:1], 1'b0};
        end else if (ex_is_jal) begin
            taken       = 1'b1;
            canRedirect = 1'b1;
        end else if (ex_is_branch) begin
            taken       = branchTaken;
            canRedirect = condValid;
        end
    end

    assign pcPlus4   = ex_pc + XLEN'(4);
    assign correctPc = taken ? takenTarget : pcPlus4;

    assign resolve    = ex_valid & (ex_is_branch | ex_is_jal | ex_is_jalr);
    assign mispredict = resolve & canRedirect & (forceMispredict | (taken != ex_pred_taken));

    // Only resolves seen in IDLE count; in REDIRECT the execute inputs are wrong-path.
    assign loadRedirect = (state == IDLE) & mispredict;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (mispredict) begin
                    stateNext = REDIRECT;
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Handshake: redirect_valid stays high and redirect_pc stays constant from the
    // cycle after the mispredict until a cycle with redirect_valid & redirect_ready.
    assign redirect_valid = (state == REDIRECT);
    assign ex_stall       = (state == REDIRECT);
    assign dbgState       = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_pc <= RESET_PC;
            flush       <= 1'b0;
        end else begin
            flush <= loadRedirect;
            if (loadRedirect) begin
                redirect_pc <= correctPc;
            end
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else begin
            if (resolve && (state == IDLE) && (stat_branches != 32'hFFFF_FFFF)) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (loadRedirect && (stat_mispredicts != 32'hFFFF_FFFF)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed literal cases followed by random
// traffic against a behavioural model with an expected-redirect queue.
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_2000;

  logic clk;
  logic reset;
  logic ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0] ex_funct3;
  logic BrEq, BrLT, BrUn;
  logic [31:0] ex_pc, ex_target;
  logic ex_pred_taken;
  logic redirect_ready, redirect_valid;
  logic [31:0] redirect_pc;
  logic flush, ex_stall, dbgState;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  logic [31:0] op_a, op_b;

  int n_checks = 0;
  int n_errors = 0;
  bit checks_on = 0;

  // model state
  logic [31:0] exp_q[$];
  logic [31:0] m_last_pc = RESET_PC;
  bit m_flush = 0;
  longint m_branches = 0;
  longint m_mispredicts = 0;

  branch_resolve_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
    .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3),
    .BrEq(BrEq), .BrLT(BrLT), .BrUn(BrUn),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .redirect_ready(redirect_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .ex_stall(ex_stall),
    .dbgState(dbgState)
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  // clock / reset
  initial clk = 0;
  always #5 clk = ~clk;

  // comparator emulation: signedness chosen from the instruction's mnemonic
  always_comb begin
    BrEq = (op_a == op_b);
    if (ex_funct3 == 3'b110 || ex_funct3 == 3'b111) BrLT = (op_a < op_b);
    else BrLT = ($signed(op_a) < $signed(op_b));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural outcome of the current execute instruction.
  function automatic bit model_redirect(output logic [31:0] npc);
    bit taken;
    npc = 32'h0;
    if (!ex_valid) return 0;
    if (ex_is_jalr) begin
      npc = ex_target & 32'hFFFF_FFFE;
      return 1;
    end
    if (ex_is_jal) begin
      npc = ex_target;
      return !ex_pred_taken;
    end
    if (!ex_is_branch) return 0;
    case (ex_funct3)
      3'b000: taken = (op_a == op_b);
      3'b001: taken = (op_a != op_b);
      3'b100: taken = ($signed(op_a) < $signed(op_b));
      3'b101: taken = ($signed(op_a) >= $signed(op_b));
      3'b110: taken = (op_a < op_b);
      3'b111: taken = (op_a >= op_b);
      default: return 0;
    endcase
    npc = taken ? ex_target : ex_pc + 32'd4;
    return taken != ex_pred_taken;
  endfunction

  // model update on each active edge (or asynchronous reset)
  initial begin
    logic [31:0] npc;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        exp_q.delete();
        m_last_pc = RESET_PC;
        m_flush = 0;
        m_branches = 0;
        m_mispredicts = 0;
      end else if (exp_q.size() != 0) begin
        m_flush = 0;
        if (redirect_ready) m_last_pc = exp_q.pop_front();
      end else begin
        m_flush = 0;
        if (ex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr)) begin
          if (m_branches < 64'hFFFF_FFFF) m_branches++;
          if (model_redirect(npc)) begin
            exp_q.push_back(npc);
            m_flush = 1;
            if (m_mispredicts < 64'hFFFF_FFFF) m_mispredicts++;
          end
        end
      end
    end
  end

  // per-cycle compare on the falling edge
  always @(negedge clk) begin
    if (checks_on) begin
      check("redirect_valid", {31'b0, redirect_valid}, {31'b0, exp_q.size() != 0});
      check("ex_stall", {31'b0, ex_stall}, {31'b0, exp_q.size() != 0});
      check("redirect_pc", redirect_pc, (exp_q.size() != 0) ? exp_q[0] : m_last_pc);
      check("flush", {31'b0, flush}, {31'b0, m_flush});
      check("BrUn", {31'b0, BrUn}, {31'b0, ex_funct3 inside {3'b010, 3'b011, 3'b110, 3'b111}});
`ifdef BRANCH_RESOLVE_STATS_EN
      check("stat_branches", stat_branches, m_branches[31:0]);
      check("stat_mispredicts", stat_mispredicts, m_mispredicts[31:0]);
`endif
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_insn(input bit v, input bit br, input bit jal, input bit jalr,
                            input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pc, input logic [31:0] tgt, input bit pred);
    ex_valid = v; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_funct3 = f3; op_a = a; op_b = b; ex_pc = pc; ex_target = tgt; ex_pred_taken = pred;
  endtask

  task automatic idle_insn();
    drive_insn(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 0;
    redirect_ready = 0;
    idle_insn();
    #2 reset = 1;
    #20;
    @(negedge clk);
    reset = 0;
    checks_on = 1;
    #1;
    check("rst_valid", {31'b0, redirect_valid}, 32'd0);
    check("rst_pc", redirect_pc, 32'h0000_2000);
    check("rst_flush", {31'b0, flush}, 32'd0);
    check("rst_stall", {31'b0, ex_stall}, 32'd0);
    step();

    // BEQ taken, predicted not taken
    drive_insn(1, 1, 0, 0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h140, 0);
    #1 check("beq_brun", {31'b0, BrUn}, 32'd0);
    step();
    idle_insn();
    check("beq_valid", {31'b0, redirect_valid}, 32'd1);
    check("beq_pc", redirect_pc, 32'h140);
    check("beq_flush", {31'b0, flush}, 32'd1);
    redirect_ready = 1;
    step();
    check("beq_done", {31'b0, redirect_valid}, 32'd0);
    check("beq_flush_off", {31'b0, flush}, 32'd0);
    redirect_ready = 0;

    // BGEU not taken, predicted not taken
    drive_insn(1, 1, 0, 0, 3'b111, 32'd1, 32'd2, 32'h180, 32'h1C0, 0);
    #1 check("bgeu_brun", {31'b0, BrUn}, 32'd1);
    step();
    idle_insn();
    check("bgeu_valid", {31'b0, redirect_valid}, 32'd0);
    check("bgeu_flush", {31'b0, flush}, 32'd0);

    // BLT not taken but predicted taken; hold ready low with a wrong-path branch
    drive_insn(1, 1, 0, 0, 3'b100, 32'd5, 32'd3, 32'h200, 32'h280, 1);
    step();
    check("blt_pc", redirect_pc, 32'h204);
    drive_insn(1, 1, 0, 0, 3'b000, 32'd7, 32'd7, 32'h500, 32'h540, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("blt_hold_valid", {31'b0, redirect_valid}, 32'd1);
      check("blt_hold_stall", {31'b0, ex_stall}, 32'd1);
      check("blt_hold_pc", redirect_pc, 32'h204);
      check("blt_hold_flush", {31'b0, flush}, 32'd0);
    end
    idle_insn();
    redirect_ready = 1;
    step();
    check("blt_release", {31'b0, redirect_valid}, 32'd0);
    redirect_ready = 0;

    // JALR clears target bit 0
    drive_insn(1, 0, 0, 1, 3'b000, 0, 0, 32'h2F0, 32'h301, 1);
    step();
    idle_insn();
    check("jalr_pc", redirect_pc, 32'h300);
    redirect_ready = 1;
    step();
    redirect_ready = 0;

    // fall-through wraps past the top of the address space
    drive_insn(1, 1, 0, 0, 3'b000, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h40, 1);
    step();
    idle_insn();
    check("wrap_pc", redirect_pc, 32'h0000_0000);
    check("wrap_valid", {31'b0, redirect_valid}, 32'd1);

    // asynchronous reset while a redirect is pending
    step();
    #2 reset = 1;
    #1;
    check("arst_valid", {31'b0, redirect_valid}, 32'd0);
    check("arst_stall", {31'b0, ex_stall}, 32'd0);
    check("arst_pc", redirect_pc, 32'h0000_2000);
`ifdef BRANCH_RESOLVE_STATS_EN
    check("arst_stat_br", stat_branches, 32'd0);
    check("arst_stat_mis", stat_mispredicts, 32'd0);
`endif
    step();
    #2 reset = 0;
    step();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, b, pc;
      int kind;
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? a : $urandom();
      if ($urandom_range(0, 7) == 0) b = a + 32'h8000_0000;
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      kind = $urandom_range(0, 9);
      drive_insn($urandom_range(0, 4) != 0,
                 kind < 7 || kind == 9, kind == 7 || kind == 9, kind == 8 || ($urandom_range(0, 19) == 0),
                 3'($urandom_range(0, 7)), a, b, pc, $urandom(), 1'($urandom_range(0, 1)));
      redirect_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    idle_insn();
    redirect_ready = 1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
